// File: rtl/mpu_irq_arb.sv
// Interrupt arbiter between four MPUs and the host. It captures each MPU's payload,
// freezes that MPU, and presents pending events one at a time in round-robin order.
module mpu_irq_arb #(
  parameter int N  = 4,
  parameter int DW = 64
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [N-1:0]    mpu_irq,
  input  logic [N*DW-1:0] mpu_data,
  output logic [N-1:0]    mpu_en,
  input  logic [N-1:0]    host_mask,
  output logic            host_irq,
  output logic [DW-1:0]   host_data,
  output logic [1:0]      host_src,
  input  logic            host_ack
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t        state;
  logic [N-1:0]  pend;
  logic [N-1:0]  elig;
  logic [DW-1:0] slot [N];
  logic [1:0]    last;
  logic [1:0]    cur;
  logic [1:0]    pick;
  logic          pick_vld;

  assign mpu_en = ~pend;
  assign elig   = pend & ~host_mask;

  // Round-robin pick: first eligible source scanning upward from last+1, wrapping mod 4.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path infers a latch.
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!pick_vld && elig[last + 2'(k)]) begin
        pick     = last + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  // NOTE: payload slots have no reset; a slot is only read while its pend flag is set.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < N; i++) begin
      if (mpu_irq[i] && !pend[i]) slot[i] <= mpu_data[i*DW +: DW];
    end
  end

  // NOTE: non-blocking assignments let capture and commit both act on pre-edge pend values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      pend      <= '0;
      last      <= 2'd3;
      cur       <= '0;
      host_irq  <= 1'b0;
      host_data <= '0;
      host_src  <= '0;
    end else begin
      // An irq arriving while its flag is still set (including the ack cycle) is dropped.
      for (int i = 0; i < N; i++) begin
        if (mpu_irq[i] && !pend[i]) pend[i] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_vld) begin
            cur       <= pick;
            host_src  <= pick;
            host_data <= slot[pick];
            host_irq  <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (host_ack) begin
            pend[cur] <= 1'b0;
            host_irq  <= 1'b0;
            last      <= cur;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_irq_arb.sv
// Directed bench for mpu_irq_arb: expected presentations are queued when irqs are
// driven and popped when the arbiter raises host_irq.
module tb_mpu_irq_arb;

  typedef struct packed {
    logic [1:0]  src;
    logic [63:0] data;
  } ev_t;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic [3:0]   mpu_irq;
  logic [255:0] mpu_data;
  logic [3:0]   mpu_en;
  logic [3:0]   host_mask;
  logic         host_irq;
  logic [63:0]  host_data;
  logic [1:0]   host_src;
  logic         host_ack;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [1:0] cur_src;
  ev_t  sb [$];

  mpu_irq_arb #(.N(4), .DW(64)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .mpu_irq  (mpu_irq),
    .mpu_data (mpu_data),
    .mpu_en   (mpu_en),
    .host_mask(host_mask),
    .host_irq (host_irq),
    .host_data(host_data),
    .host_src (host_src),
    .host_ack (host_ack)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [63:0] v);
    mpu_data[i*64 +: 64] = v;
  endtask

  task automatic push(input logic [1:0] s, input logic [63:0] d);
    ev_t e;
    e.src  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  // Wait up to budget cycles for host_irq, then compare against the scoreboard head.
  task automatic expect_present(input int budget);
    ev_t e;
    int  n = 0;
    while (host_irq !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("present_irq", 64'(host_irq), 64'd1);
    if (host_irq === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("present_src", 64'(host_src), 64'(e.src));
        check("present_data", host_data, e.data);
        check("present_en_frozen", 64'(mpu_en[e.src]), 64'd0);
        cur_src = e.src;
      end
    end
  endtask

  // Pulse host_ack, optionally with an irq in the same cycle, then check the release.
  task automatic commit(input logic [3:0] irq_at_ack, input logic [63:0] d);
    host_ack = 1'b1;
    mpu_irq  = irq_at_ack;
    for (int i = 0; i < 4; i++) set_slot(i, d);
    step();
    host_ack = 1'b0;
    mpu_irq  = '0;
    check("ack_irq_low", 64'(host_irq), 64'd0);
    check("ack_en_restored", 64'(mpu_en[cur_src]), 64'd1);
  endtask

  initial begin
    sys_rst   = 1'b1;
    mpu_irq   = '0;
    mpu_data  = '0;
    host_mask = '0;
    host_ack  = 1'b0;
    cur_src   = '0;
    step();
    step();
    sys_rst = 1'b0;
    cyc     = 0;
    check("rst_en", 64'(mpu_en), 64'hF);
    check("rst_irq", 64'(host_irq), 64'd0);
    check("rst_data", host_data, 64'd0);
    check("rst_src", 64'(host_src), 64'd0);

    // Single event with exact latencies: irq at 10, en at 11, present at 12, ack at 15.
    while (cyc < 10) step();
    mpu_irq = 4'b0001;
    set_slot(0, 64'hDEAD_BEEF_0000_0001);
    push(2'd0, 64'hDEAD_BEEF_0000_0001);
    step();
    mpu_irq = '0;
    check("t1_en_frozen", 64'(mpu_en), 64'hE);
    check("t1_irq_not_yet", 64'(host_irq), 64'd0);
    step();
    expect_present(0);
    while (cyc < 15) step();
    check("t1_hold_irq", 64'(host_irq), 64'd1);
    commit(4'b0000, 64'd0);
    check("t1_en_all", 64'(mpu_en), 64'hF);
    step();
    check("t1_idle_irq", 64'(host_irq), 64'd0);

    // Fresh reset, then all four at once: served 0,1,2,3 with a low gap between.
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    mpu_irq = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      set_slot(i, 64'(i + 1));
      push(2'(i), 64'(i + 1));
    end
    step();
    mpu_irq = '0;
    check("t2_en_frozen", 64'(mpu_en), 64'h0);
    for (int i = 0; i < 4; i++) begin
      expect_present(5);
      step();
      check("t2_hold_irq", 64'(host_irq), 64'd1);
      commit(4'b0000, 64'd0);
    end

    // Fairness: serve src 2, then src 0 and 3 together -> 3 before 0.
    mpu_irq = 4'b0100;
    set_slot(2, 64'h22);
    push(2'd2, 64'h22);
    step();
    mpu_irq = '0;
    expect_present(5);
    commit(4'b0000, 64'd0);
    mpu_irq = 4'b1001;
    set_slot(0, 64'h30);
    set_slot(3, 64'h33);
    push(2'd3, 64'h33);
    push(2'd0, 64'h30);
    step();
    mpu_irq = '0;
    expect_present(5);
    commit(4'b0000, 64'd0);
    expect_present(5);
    commit(4'b0000, 64'd0);

    // Mask holds src 1 off; unmasking in cycle u presents in u+1.
    host_mask = 4'b0010;
    mpu_irq   = 4'b0010;
    set_slot(1, 64'h41);
    push(2'd1, 64'h41);
    step();
    mpu_irq = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("t4_masked_irq", 64'(host_irq), 64'd0);
      check("t4_masked_en", 64'(mpu_en[1]), 64'd0);
    end
    host_mask = 4'b0000;
    step();
    expect_present(0);
    commit(4'b0000, 64'd0);

    // Re-irq while pending is ignored; irq in the ack cycle is dropped.
    mpu_irq = 4'b0001;
    set_slot(0, 64'h51);
    push(2'd0, 64'h51);
    step();
    set_slot(0, 64'h52);
    step();
    mpu_irq = '0;
    expect_present(0);
    commit(4'b0001, 64'h53);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_dropped_irq", 64'(host_irq), 64'd0);
      check("t5_dropped_en", 64'(mpu_en), 64'hF);
    end

    // Reset mid-PRESENT with three pending discards everything.
    mpu_irq = 4'b1011;
    set_slot(0, 64'h60);
    set_slot(1, 64'h61);
    set_slot(3, 64'h63);
    push(2'd1, 64'h61);
    push(2'd3, 64'h63);
    push(2'd0, 64'h60);
    step();
    mpu_irq = '0;
    expect_present(5);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    sb.delete();
    check("t6_rst_en", 64'(mpu_en), 64'hF);
    check("t6_rst_irq", 64'(host_irq), 64'd0);
    check("t6_rst_src", 64'(host_src), 64'd0);
    check("t6_rst_data", host_data, 64'd0);
    step();
    check("t6_post_rst_irq", 64'(host_irq), 64'd0);
    mpu_irq = 4'b0100;
    set_slot(2, 64'h62);
    push(2'd2, 64'h62);
    step();
    mpu_irq = '0;
    expect_present(5);
    commit(4'b0000, 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
